// File: rtl/wishbone_master_if_ext_pkg.sv
`default_nettype none
// ============================================================================
// Module   : wishbone_master_if_ext_pkg
// Purpose  : Shared constants for the Wishbone master bus interface.
// Revision : 1.0 - initial release
// ============================================================================
package wishbone_master_if_ext_pkg;

    localparam logic        RstEnable = 1'b1;
    localparam logic        Stop      = 1'b1;
    localparam logic        NoStop    = 1'b0;
    localparam logic [31:0] ZeroWord  = 32'h0000_0000;

    localparam logic [1:0] WB_IDLE           = 2'b00;
    localparam logic [1:0] WB_BUSY           = 2'b01;
    localparam logic [1:0] WB_RETRY_GAP      = 2'b10;
    localparam logic [1:0] WB_WAIT_FOR_STALL = 2'b11;

    localparam logic [1:0] WB_ERR_NONE = 2'b00;
    localparam logic [1:0] WB_ERR_ERR  = 2'b01;
    localparam logic [1:0] WB_ERR_RTY  = 2'b10;
    localparam logic [1:0] WB_ERR_TMO  = 2'b11;

endpackage
`default_nettype wire

// File: rtl/wishbone_master_if_ext_watchdog.sv
`default_nettype none
// ============================================================================
// Module   : wb_watchdog
// Purpose  : Loadable saturating cycle counter; expire flags LIMIT-1 reached.
// Revision : 1.0 - initial release
// ============================================================================
module wb_watchdog #(
    parameter int LIMIT = 256,
    parameter int CNT_W = 9
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expire
);

    generate
        if (LIMIT == 0) begin : g_disabled
            assign expire = 1'b0;
        end else begin : g_enabled
            logic [CNT_W-1:0] r_count;

            // Saturates rather than wraps so a long stall never re-arms the compare.
            always_ff @(posedge clk) begin
                if (rst || load) begin
                    r_count <= '0;
                end else if (en && (r_count != '1)) begin
                    r_count <= r_count + CNT_W'(1);
                end
            end

            assign expire = (r_count == CNT_W'(LIMIT - 1));
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/wishbone_master_if_ext.sv
`default_nettype none
// ============================================================================
// Module   : wishbone_master_if_ext
// Purpose  : Single-outstanding Wishbone B3 classic master with ERR/RTY and
//            timeout handling, bridging one CPU memory port onto the bus.
// Revision : 1.0 - initial release
// ============================================================================
module wishbone_master_if_ext
    import wishbone_master_if_ext_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int STALL_W     = 6,
    parameter int MAX_RETRY   = 3,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [STALL_W-1:0]  stall_i,
    input  logic                flush_i,
    input  logic                cpu_ce_i,
    input  logic [DATA_W-1:0]   cpu_data_i,
    input  logic [ADDR_W-1:0]   cpu_addr_i,
    input  logic                cpu_we_i,
    input  logic [DATA_W/8-1:0] cpu_sel_i,
    output logic [DATA_W-1:0]   cpu_data_o,
    output logic                stallreq,
    input  logic [DATA_W-1:0]   wishbone_data_i,
    input  logic                wishbone_ack_i,
    input  logic                wishbone_err_i,
    input  logic                wishbone_rty_i,
    output logic [ADDR_W-1:0]   wishbone_addr_o,
    output logic [DATA_W-1:0]   wishbone_data_o,
    output logic                wishbone_we_o,
    output logic [DATA_W/8-1:0] wishbone_sel_o,
    output logic                wishbone_stb_o,
    output logic                wishbone_cyc_o,
    output logic                bus_err_o,
    output logic [1:0]          bus_err_cause_o,
    output logic [ADDR_W-1:0]   bus_err_addr_o
);

    localparam int SEL_W = DATA_W / 8;
    localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int TMO_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] w_wdata_nxt;
    logic              r_we;
    logic              w_we_nxt;
    logic [SEL_W-1:0]  r_sel;
    logic [SEL_W-1:0]  w_sel_nxt;
    logic              r_stb;
    logic              w_stb_nxt;
    logic              r_cyc;
    logic              w_cyc_nxt;
    logic [DATA_W-1:0] r_read_buf;
    logic [DATA_W-1:0] w_read_buf_nxt;
    logic [RTY_W-1:0]  r_retry_cnt;
    logic [RTY_W-1:0]  w_retry_nxt;
    logic              r_bus_err;
    logic              w_bus_err_nxt;
    logic [1:0]        r_err_cause;
    logic [1:0]        w_err_cause_nxt;
    logic [ADDR_W-1:0] r_err_addr;
    logic [ADDR_W-1:0] w_err_addr_nxt;

    logic              w_abort;
    logic [1:0]        w_abort_cause;
    logic              w_tmo_load;
    logic              w_tmo_inc;
    logic              w_tmo_expire;
    logic [STALL_W-1:0] w_stall_idle;

    assign w_stall_idle = '0;

    wb_watchdog #(
        .LIMIT (TIMEOUT_CYC),
        .CNT_W (TMO_W)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .load   (w_tmo_load),
        .en     (w_tmo_inc),
        .expire (w_tmo_expire)
    );

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_state     <= WB_IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_we        <= 1'b0;
            r_sel       <= '0;
            r_stb       <= 1'b0;
            r_cyc       <= 1'b0;
            r_read_buf  <= '0;
            r_retry_cnt <= '0;
            r_bus_err   <= 1'b0;
            r_err_cause <= WB_ERR_NONE;
            r_err_addr  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_we        <= w_we_nxt;
            r_sel       <= w_sel_nxt;
            r_stb       <= w_stb_nxt;
            r_cyc       <= w_cyc_nxt;
            r_read_buf  <= w_read_buf_nxt;
            r_retry_cnt <= w_retry_nxt;
            r_bus_err   <= w_bus_err_nxt;
            r_err_cause <= w_err_cause_nxt;
            r_err_addr  <= w_err_addr_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_wdata_nxt     = r_wdata;
        w_we_nxt        = r_we;
        w_sel_nxt       = r_sel;
        w_stb_nxt       = r_stb;
        w_cyc_nxt       = r_cyc;
        w_read_buf_nxt  = r_read_buf;
        w_retry_nxt     = r_retry_cnt;
        w_bus_err_nxt   = 1'b0;
        w_err_cause_nxt = r_err_cause;
        w_err_addr_nxt  = r_err_addr;
        w_abort         = 1'b0;
        w_abort_cause   = WB_ERR_NONE;
        w_tmo_load      = 1'b0;
        w_tmo_inc       = 1'b0;
        stallreq        = 1'b0;
        cpu_data_o      = '0;

        case (r_state)
            WB_IDLE: begin
                if (cpu_ce_i && !flush_i) begin
                    w_addr_nxt  = cpu_addr_i;
                    w_wdata_nxt = cpu_data_i;
                    w_we_nxt    = cpu_we_i;
                    w_sel_nxt   = cpu_sel_i;
                    w_stb_nxt   = 1'b1;
                    w_cyc_nxt   = 1'b1;
                    w_retry_nxt = '0;
                    w_tmo_load  = 1'b1;
                    w_state_nxt = WB_BUSY;
                    stallreq    = 1'b1;
                end
            end

            WB_BUSY: begin
                if (wishbone_ack_i) begin
                    w_addr_nxt  = '0;
                    w_wdata_nxt = '0;
                    w_we_nxt    = 1'b0;
                    w_sel_nxt   = '0;
                    w_stb_nxt   = 1'b0;
                    w_cyc_nxt   = 1'b0;
                    if (!r_we) begin
                        w_read_buf_nxt = wishbone_data_i;
                        cpu_data_o     = wishbone_data_i;
                    end
                    w_state_nxt = (stall_i != w_stall_idle) ? WB_WAIT_FOR_STALL : WB_IDLE;
                end else if (wishbone_err_i) begin
                    w_abort       = 1'b1;
                    w_abort_cause = WB_ERR_ERR;
                end else if (wishbone_rty_i) begin
                    if (r_retry_cnt < RTY_W'(MAX_RETRY)) begin
                        // Address, data and selects stay put for the reissue.
                        w_stb_nxt   = 1'b0;
                        w_cyc_nxt   = 1'b0;
                        w_retry_nxt = r_retry_cnt + RTY_W'(1);
                        w_state_nxt = WB_RETRY_GAP;
                        stallreq    = 1'b1;
                    end else begin
                        w_abort       = 1'b1;
                        w_abort_cause = WB_ERR_RTY;
                    end
                end else if (w_tmo_expire) begin
                    w_abort       = 1'b1;
                    w_abort_cause = WB_ERR_TMO;
                end else if (flush_i) begin
                    w_addr_nxt     = '0;
                    w_wdata_nxt    = '0;
                    w_we_nxt       = 1'b0;
                    w_sel_nxt      = '0;
                    w_stb_nxt      = 1'b0;
                    w_cyc_nxt      = 1'b0;
                    w_read_buf_nxt = '0;
                    w_state_nxt    = WB_IDLE;
                end else begin
                    w_tmo_inc = 1'b1;
                    stallreq  = 1'b1;
                end
            end

            WB_RETRY_GAP: begin
                stallreq = 1'b1;
                if (flush_i) begin
                    w_addr_nxt     = '0;
                    w_wdata_nxt    = '0;
                    w_we_nxt       = 1'b0;
                    w_sel_nxt      = '0;
                    w_read_buf_nxt = '0;
                    w_state_nxt    = WB_IDLE;
                end else begin
                    w_stb_nxt   = 1'b1;
                    w_cyc_nxt   = 1'b1;
                    w_tmo_load  = 1'b1;
                    w_state_nxt = WB_BUSY;
                end
            end

            default: begin
                cpu_data_o = r_read_buf;
                if (stall_i == w_stall_idle) begin
                    w_state_nxt = WB_IDLE;
                end
            end
        endcase

        // Every error-class termination ends like an ack but with zero data and a pulse.
        if (w_abort) begin
            w_addr_nxt      = '0;
            w_wdata_nxt     = '0;
            w_we_nxt        = 1'b0;
            w_sel_nxt       = '0;
            w_stb_nxt       = 1'b0;
            w_cyc_nxt       = 1'b0;
            w_read_buf_nxt  = '0;
            w_bus_err_nxt   = 1'b1;
            w_err_cause_nxt = w_abort_cause;
            w_err_addr_nxt  = r_addr;
            w_state_nxt     = (stall_i != w_stall_idle) ? WB_WAIT_FOR_STALL : WB_IDLE;
        end
    end

    assign wishbone_addr_o = r_addr;
    assign wishbone_data_o = r_wdata;
    assign wishbone_we_o   = r_we;
    assign wishbone_sel_o  = r_sel;
    assign wishbone_stb_o  = r_stb;
    assign wishbone_cyc_o  = r_cyc;
    assign bus_err_o       = r_bus_err;
    assign bus_err_cause_o = r_err_cause;
    assign bus_err_addr_o  = r_err_addr;

endmodule
`default_nettype wire

// File: tb/tb_wishbone_master_if_ext.sv
`default_nettype none
// ============================================================================
// Module   : tb_wishbone_master_if_ext
// Purpose  : Directed self-checking bench for wishbone_master_if_ext.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wishbone_master_if_ext;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic        cpu_ce_i;
    logic [31:0] cpu_data_i;
    logic [31:0] cpu_addr_i;
    logic        cpu_we_i;
    logic [3:0]  cpu_sel_i;
    logic [31:0] cpu_data_o;
    logic        stallreq;
    logic [31:0] wishbone_data_i;
    logic        wishbone_ack_i;
    logic        wishbone_err_i;
    logic        wishbone_rty_i;
    logic [31:0] wishbone_addr_o;
    logic [31:0] wishbone_data_o;
    logic        wishbone_we_o;
    logic [3:0]  wishbone_sel_o;
    logic        wishbone_stb_o;
    logic        wishbone_cyc_o;
    logic        bus_err_o;
    logic [1:0]  bus_err_cause_o;
    logic [31:0] bus_err_addr_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    wishbone_master_if_ext #(
        .DATA_W      (32),
        .ADDR_W      (32),
        .STALL_W     (6),
        .MAX_RETRY   (3),
        .TIMEOUT_CYC (16)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .cpu_ce_i        (cpu_ce_i),
        .cpu_data_i      (cpu_data_i),
        .cpu_addr_i      (cpu_addr_i),
        .cpu_we_i        (cpu_we_i),
        .cpu_sel_i       (cpu_sel_i),
        .cpu_data_o      (cpu_data_o),
        .stallreq        (stallreq),
        .wishbone_data_i (wishbone_data_i),
        .wishbone_ack_i  (wishbone_ack_i),
        .wishbone_err_i  (wishbone_err_i),
        .wishbone_rty_i  (wishbone_rty_i),
        .wishbone_addr_o (wishbone_addr_o),
        .wishbone_data_o (wishbone_data_o),
        .wishbone_we_o   (wishbone_we_o),
        .wishbone_sel_o  (wishbone_sel_o),
        .wishbone_stb_o  (wishbone_stb_o),
        .wishbone_cyc_o  (wishbone_cyc_o),
        .bus_err_o       (bus_err_o),
        .bus_err_cause_o (bus_err_cause_o),
        .bus_err_addr_o  (bus_err_addr_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change 1 ns after the edge, checks 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic request(input logic [31:0] addr, input logic we,
                           input logic [31:0] data, input logic [3:0] sel);
        cpu_ce_i   = 1'b1;
        cpu_addr_i = addr;
        cpu_we_i   = we;
        cpu_data_i = data;
        cpu_sel_i  = sel;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got stuck, expected completion");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst = 1'b1; stall_i = '0; flush_i = 1'b0; cpu_ce_i = 1'b0;
        cpu_data_i = '0; cpu_addr_i = '0; cpu_we_i = 1'b0; cpu_sel_i = '0;
        wishbone_data_i = '0; wishbone_ack_i = 1'b0; wishbone_err_i = 1'b0;
        wishbone_rty_i = 1'b0;
        tick(); tick();
        settle();
        chk("rst_cyc", wishbone_cyc_o, 0);
        chk("rst_stb", wishbone_stb_o, 0);
        chk("rst_stallreq", stallreq, 0);
        chk("rst_cpu_data", cpu_data_o, 0);
        chk("rst_bus_err", bus_err_o, 0);
        chk("rst_cause", bus_err_cause_o, 0);
        tick();
        rst = 1'b0;

        // Zero-wait read
        request(32'h0000_1000, 1'b0, 32'h0, 4'hF);
        settle();
        chk("rd_stallreq_req", stallreq, 1);
        tick();
        cpu_ce_i = 1'b0; wishbone_ack_i = 1'b1; wishbone_data_i = 32'hDEAD_BEEF;
        settle();
        chk("rd_cyc", wishbone_cyc_o, 1);
        chk("rd_addr", wishbone_addr_o, 32'h0000_1000);
        chk("rd_cpu_data", cpu_data_o, 32'hDEAD_BEEF);
        chk("rd_stallreq_ack", stallreq, 0);
        tick();
        wishbone_ack_i = 1'b0;
        settle();
        chk("rd_cyc_after", wishbone_cyc_o, 0);
        chk("rd_cpu_data_idle", cpu_data_o, 0);

        // Write with three wait states
        request(32'h0000_2000, 1'b1, 32'h1234_5678, 4'b0011);
        settle();
        chk("wr_stallreq_req", stallreq, 1);
        tick();
        cpu_ce_i = 1'b0; cpu_data_i = 32'h0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("wr_stallreq_wait", stallreq, 1);
            chk("wr_data_o", wishbone_data_o, 32'h1234_5678);
            chk("wr_sel_o", wishbone_sel_o, 4'b0011);
            chk("wr_we_o", wishbone_we_o, 1);
            tick();
        end
        wishbone_ack_i = 1'b1;
        settle();
        chk("wr_stallreq_ack", stallreq, 0);
        chk("wr_cpu_data", cpu_data_o, 0);
        tick();
        wishbone_ack_i = 1'b0;
        settle();
        chk("wr_cyc_after", wishbone_cyc_o, 0);
        chk("wr_no_err", bus_err_o, 0);

        // Read completing while the pipeline is stalled
        request(32'h0000_3000, 1'b0, 32'h0, 4'hF);
        tick();
        cpu_ce_i = 1'b0; wishbone_ack_i = 1'b1; wishbone_data_i = 32'hCAFE_F00D;
        stall_i = 6'b000011;
        settle();
        chk("st_ack_data", cpu_data_o, 32'hCAFE_F00D);
        tick();
        wishbone_ack_i = 1'b0; wishbone_data_i = 32'h1111_1111;
        settle();
        chk("st_w1_stallreq", stallreq, 0);
        chk("st_w1_data", cpu_data_o, 32'hCAFE_F00D);
        tick();
        stall_i = 6'b000000;
        settle();
        chk("st_w2_stallreq", stallreq, 0);
        chk("st_w2_data", cpu_data_o, 32'hCAFE_F00D);
        tick();
        settle();
        chk("st_idle_data", cpu_data_o, 0);

        // Retry on every attempt, exhausting MAX_RETRY=3
        request(32'h0000_4000, 1'b0, 32'h0, 4'hF);
        tick();
        cpu_ce_i = 1'b0;
        for (int a = 0; a < 4; a++) begin
            wishbone_rty_i = 1'b1;
            settle();
            chk("rty_cyc_attempt", wishbone_cyc_o, 1);
            tick();
            wishbone_rty_i = 1'b0;
            settle();
            chk("rty_cyc_dropped", wishbone_cyc_o, 0);
            if (a < 3) begin
                chk("rty_gap_stallreq", stallreq, 1);
                chk("rty_gap_no_err", bus_err_o, 0);
                tick();
            end
        end
        chk("rty_err_pulse", bus_err_o, 1);
        chk("rty_cause", bus_err_cause_o, 2'b10);
        chk("rty_addr", bus_err_addr_o, 32'h0000_4000);
        tick();
        settle();
        chk("rty_pulse_end", bus_err_o, 0);
        chk("rty_cause_held", bus_err_cause_o, 2'b10);

        // Silent slave, TIMEOUT_CYC=16
        request(32'h0000_5000, 1'b0, 32'h0, 4'hF);
        tick();
        cpu_ce_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            settle();
            chk("tmo_stb_held", wishbone_stb_o, 1);
            tick();
        end
        settle();
        chk("tmo_stb_dropped", wishbone_stb_o, 0);
        chk("tmo_err_pulse", bus_err_o, 1);
        chk("tmo_cause", bus_err_cause_o, 2'b11);
        chk("tmo_addr", bus_err_addr_o, 32'h0000_5000);
        tick();

        // Flush on the second BUSY cycle, then a late ack
        request(32'h0000_6000, 1'b0, 32'h0, 4'hF);
        tick();
        cpu_ce_i = 1'b0;
        settle();
        chk("fl_busy1_cyc", wishbone_cyc_o, 1);
        tick();
        flush_i = 1'b1;
        settle();
        chk("fl_busy2_cyc", wishbone_cyc_o, 1);
        tick();
        flush_i = 1'b0; wishbone_ack_i = 1'b1; wishbone_data_i = 32'hAAAA_5555;
        settle();
        chk("fl_cyc_dropped", wishbone_cyc_o, 0);
        chk("fl_late_ack_data", cpu_data_o, 0);
        chk("fl_stallreq", stallreq, 0);
        tick();
        wishbone_ack_i = 1'b0;
        settle();
        chk("fl_no_err", bus_err_o, 0);
        chk("fl_cause_held", bus_err_cause_o, 2'b11);

        // Simultaneous ack+err behaves as ack
        request(32'h0000_7000, 1'b0, 32'h0, 4'hF);
        tick();
        cpu_ce_i = 1'b0; wishbone_ack_i = 1'b1; wishbone_err_i = 1'b1;
        wishbone_data_i = 32'h0BAD_F00D;
        settle();
        chk("ae_cpu_data", cpu_data_o, 32'h0BAD_F00D);
        tick();
        wishbone_ack_i = 1'b0; wishbone_err_i = 1'b0;
        settle();
        chk("ae_no_err", bus_err_o, 0);

        // Plain ERR termination
        request(32'h0000_8000, 1'b0, 32'h0, 4'hF);
        tick();
        cpu_ce_i = 1'b0; wishbone_err_i = 1'b1; wishbone_data_i = 32'h5A5A_5A5A;
        settle();
        chk("err_cpu_data", cpu_data_o, 0);
        chk("err_stallreq", stallreq, 0);
        tick();
        wishbone_err_i = 1'b0;
        settle();
        chk("err_pulse", bus_err_o, 1);
        chk("err_cause", bus_err_cause_o, 2'b01);
        chk("err_addr", bus_err_addr_o, 32'h0000_8000);
        chk("err_cyc", wishbone_cyc_o, 0);
        tick();

        // Reset in the middle of a transfer
        request(32'h0000_9000, 1'b0, 32'h0, 4'hF);
        tick();
        cpu_ce_i = 1'b0;
        settle();
        chk("mr_cyc_busy", wishbone_cyc_o, 1);
        rst = 1'b1;
        tick();
        settle();
        chk("mr_cyc_dropped", wishbone_cyc_o, 0);
        chk("mr_no_err", bus_err_o, 0);
        rst = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
